demux_deser8: RTL and testbench
===============================

// Module: demux_deser8
// PURPOSE
//   Serial-to-parallel receiver paired with the mux8to1 serializer: accepts one bit per
//   valid/ready beat and steers bit k into lane k of an assembly register (LSB first).
//   The completed word moves into a one-entry output register with its own valid/ready
//   handshake. Sits at the receive end of the bit-serial link feeding byte-wide logic.
// PARAMETERS
//   WIDTH   8   lanes per word; power of two, >= 2. SEL_W = $clog2(WIDTH) is a localparam.
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   flush      in   1      synchronous discard of the partially assembled word
//   in_bit     in   1      serial data bit
//   in_valid   in   1      in_bit is valid this cycle
//   in_ready   out  1      block accepts in_bit this cycle
//   out_data   out  WIDTH  assembled word; lane k = k-th accepted bit
//   out_valid  out  1      out_data is held and valid
//   out_ready  in   1      consumer takes out_data this cycle
//   out_perr   out  1      parity error for out_data (PARITY_CHECK_EN only; else tied 0)
// BEHAVIOUR
//   - Reset (rst_n low, async): sel=0, assembly reg=0, out_data=0, out_valid=0, out_perr=0.
//   - Accept = in_valid && in_ready. On accept, assembly[sel] <= in_bit (one-hot write
//     enable from decoder); sel increments.
//   - Last beat = sel==WIDTH-1 (or the parity beat with PARITY_CHECK_EN). On accepting it:
//     sel <= 0; out_data <= assembly with the current bit merged; out_valid <= 1 next cycle.
//     Latency: last bit accepted in cycle N -> out_valid high in cycle N+1.
//   - in_ready = !last_beat || !out_valid || out_ready. Non-final beats are never stalled;
//     the final beat stalls only while the output register is full and not draining.
//   - Output: out_valid && out_ready clears out_valid unless a new word loads in that same
//     cycle, in which case out_valid stays 1 and out_data takes the new word (no bubble).
//   - out_data/out_perr are stable while out_valid && !out_ready.
//   - flush: sel <= 0 and assembly cleared; the bit offered that cycle is dropped even if
//     in_valid=1 (in_ready is still computed normally; flush wins). Output register and
//     out_valid unaffected.
//   - sel wraps WIDTH-1 -> 0 (or parity beat -> 0); no other wrap path.
//   - Reset asserted mid-word or with out_valid high discards everything immediately.
// CONFIGURATION
//   PARITY_CHECK_EN (defined): each word is WIDTH data beats followed by one even-parity
//   beat (sel == WIDTH; sel width SEL_W+1). The parity beat is the last beat; it is not
//   stored; out_perr <= ^data ^ parity_bit, loaded together with out_data.
//   Undefined: WIDTH beats per word, no parity state, out_perr is a constant 0.
// STRUCTURE
//   - Package demux_deser_pkg: default WIDTH constant, sel_t typedef, PARITY_BEAT constant.
//   - Sub-module demux1to8 (combinational): sel + enable -> WIDTH one-hot lane write enables;
//     instantiated once as the lane steering decoder.
//   - Top: sel counter, assembly register, output register + handshake, optional parity.
// TESTING
//   1. Reset, then 8 beats 1,0,1,1,0,0,1,0 with out_ready=1 -> out_data=8'h4D, out_valid
//      high exactly one cycle, the cycle after beat 8.
//   2. Two words back-to-back (8'hA5, 8'h3C), out_ready=0 -> after word 1 out_valid=1 held;
//      8th beat of word 2 sees in_ready=0; raise out_ready -> 8'hA5 then 8'h3C, no bit loss.
//   3. Drain and load same cycle: out_ready=1 on the cycle the final beat of 8'hFF is
//      accepted while 8'h01 is held -> out_valid stays 1, next out_data=8'hFF.
//   4. Flush after 3 beats, flush cycle also carries in_valid=1 -> then 8'h0F sent
//      -> out_data=8'h0F; partial bits and the flush-cycle bit absent.
//   5. rst_n low after 5 beats with out_valid=1 -> all outputs 0 async; next full word
//      assembles from lane 0.
//   6. PARITY_CHECK_EN: 8'h07 + parity 1 -> out_perr=0; 8'h07 + parity 0 -> out_perr=1;
//      9th beat stalls when output full.

Source files
------------

// File: rtl/demux_deser_pkg.sv
// Shared constants and types for the demux_deser8 bit-serial receiver.
// Build option: PARITY_CHECK_EN appends one even-parity beat to every word.
package demux_deser_pkg;

    localparam int DEFAULT_WIDTH = 8;

`ifdef PARITY_CHECK_EN
    localparam int SEL_BITS = $clog2(DEFAULT_WIDTH) + 1;
`else
    localparam int SEL_BITS = $clog2(DEFAULT_WIDTH);
`endif

    typedef logic [SEL_BITS-1:0] sel_t;

    // Beat index that carries the parity bit; it sits just past the last data lane.
    localparam int PARITY_BEAT = DEFAULT_WIDTH;

endpackage

// File: rtl/demux1to8.sv
// Lane steering decoder: turns the beat counter into one-hot lane write enables.
// Counter values past the last lane (the parity beat) enable no lane.
module demux1to8 #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] lane_en_o
);

    always_comb begin
        lane_en_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lane_en_o[i] = en_i && (sel_i == SEL_W'(i));
        end
    end

endmodule

// File: rtl/demux_deser8.sv
// Serial-to-parallel receiver: one bit per valid/ready beat, LSB first, into a
// one-entry output register. Build option: PARITY_CHECK_EN (trailing even-parity beat).
module demux_deser8
    import demux_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_perr
);

    localparam int SEL_W = $clog2(WIDTH);
`ifdef PARITY_CHECK_EN
    localparam int CNT_W = SEL_W + 1;
    localparam logic [CNT_W-1:0] LAST_SEL = CNT_W'(WIDTH);
`else
    localparam int CNT_W = SEL_W;
    localparam logic [CNT_W-1:0] LAST_SEL = CNT_W'(WIDTH - 1);
`endif

    // Handshakes: a beat moves on in_valid && in_ready, a word on out_valid && out_ready;
    // neither side may make its valid depend on the other side's ready.
    logic [CNT_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] asm_q, asm_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] lane_en;
    logic [WIDTH-1:0] merged;
    logic             last_beat;
    logic             accept;
    logic             load;
    logic             out_fire;

    assign last_beat = (sel_q == LAST_SEL);
    assign in_ready  = !last_beat || !valid_q || out_ready;
    // flush wins over a beat offered in the same cycle.
    assign accept    = in_valid && in_ready && !flush;
    assign load      = accept && last_beat;
    assign out_fire  = valid_q && out_ready;

    demux1to8 #(
        .WIDTH(WIDTH),
        .SEL_W(CNT_W)
    ) u_lane_dec (
        .sel_i    (sel_q),
        .en_i     (accept),
        .lane_en_o(lane_en)
    );

    always_comb begin
        merged = asm_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (lane_en[i]) begin
                merged[i] = in_bit;
            end
        end
    end

    always_comb begin
        sel_d   = sel_q;
        asm_d   = asm_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (flush) begin
            sel_d = '0;
            asm_d = '0;
        end else if (accept) begin
            asm_d = merged;
            sel_d = last_beat ? '0 : sel_q + CNT_W'(1);
        end
        // A load in the same cycle as a drain keeps out_valid high with no bubble.
        if (load) begin
            data_d  = merged;
            valid_d = 1'b1;
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef PARITY_CHECK_EN
    logic perr_q, perr_d;

    always_comb begin
        perr_d = perr_q;
        if (load) begin
            perr_d = (^asm_q) ^ in_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign out_perr = perr_q;
`else
    assign out_perr = 1'b0;
`endif

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_demux_deser8.sv
// Self-checking bench for demux_deser8: table-driven first word, directed corner
// sequences, then random traffic against a queue-based reference model.
module tb_demux_deser8;

    localparam int W = 8;
`ifdef PARITY_CHECK_EN
    localparam int BEATS = W + 1;
`else
    localparam int BEATS = W;
`endif

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_bit;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_perr;

    demux_deser8 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_bit   (in_bit),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_perr (out_perr)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       bits[$];        // beats accepted into the current word
    logic [W:0] exp_q[$];       // {perr, data} of the word held in the output register

    typedef struct {
        logic         f;
        logic         v;
        logic         b;
        logic         r;
        logic         exp_rdy;
        logic         exp_valid;
        logic [W-1:0] exp_data;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic par(input logic [W-1:0] w);
        return ^w;
    endfunction

    function automatic logic beat_bit(input logic [W-1:0] w, input logic p, input int k);
        return (k < W) ? w[k] : p;
    endfunction

    // One clock cycle: drive inputs, check against the model before the edge,
    // advance the model to what the edge should produce.
    task automatic cycle(input logic f, input logic v, input logic b, input logic r,
                         output logic rdy_seen);
        logic       rdy_exp;
        logic       hs;
        logic       ld;
        logic [W:0] e;
        flush = f; in_valid = v; in_bit = b; out_ready = r;
        e  = '0;
        ld = 1'b0;
        @(negedge clk);
        rdy_seen = in_ready;
        rdy_exp  = (bits.size() != BEATS - 1) || (exp_q.size() == 0) || r;
        check("model_in_ready", in_ready, rdy_exp);
        check("model_out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("model_out_data", out_data, exp_q[0][W-1:0]);
            check("model_out_perr", out_perr, exp_q[0][W]);
        end
        hs = (exp_q.size() != 0) && r;
        if (f) begin
            bits.delete();
        end else if (v && rdy_exp) begin
            bits.push_back(b);
            if (bits.size() == BEATS) begin
                for (int i = 0; i < W; i++) e[i] = bits[i];
`ifdef PARITY_CHECK_EN
                e[W] = (^e[W-1:0]) ^ bits[W];
`endif
                ld = 1'b1;
                bits.delete();
            end
        end
        if (hs) void'(exp_q.pop_front());
        if (ld) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input logic [W-1:0] w, input logic p, input int n, input logic r);
        logic rdy;
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b1, beat_bit(w, p, k), r, rdy);
    endtask

    task automatic idle(input logic r);
        logic rdy;
        cycle(1'b0, 1'b0, 1'b0, r, rdy);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic rdy;
        rst_n = 1'b0; flush = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, 8'h00);
        check("reset_out_perr", out_perr, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        // Test 1: bits 1,0,1,1,0,0,1,0 LSB first -> 8'h4D, valid for exactly one cycle.
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00});
`ifdef PARITY_CHECK_EN
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h4D});
`else
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h4D});
`endif
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h4D});
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].f, tbl[i].v, tbl[i].b, tbl[i].r, rdy);
            check("t1_in_ready", rdy, tbl[i].exp_rdy);
            check("t1_out_valid", out_valid, tbl[i].exp_valid);
            check("t1_out_data", out_data, tbl[i].exp_data);
        end

        // Test 2: two words with the consumer stalled; final beat of word 2 waits.
        send_beats(8'hA5, par(8'hA5), BEATS, 1'b0);
        check("t2_held_valid", out_valid, 1'b1);
        check("t2_held_data", out_data, 8'hA5);
        send_beats(8'h3C, par(8'h3C), BEATS - 1, 1'b0);
        cycle(1'b0, 1'b1, beat_bit(8'h3C, par(8'h3C), BEATS - 1), 1'b0, rdy);
        check("t2_stall_ready", rdy, 1'b0);
        check("t2_still_a5", out_data, 8'hA5);
        cycle(1'b0, 1'b1, beat_bit(8'h3C, par(8'h3C), BEATS - 1), 1'b1, rdy);
        check("t2_release_ready", rdy, 1'b1);
        check("t2_word2_valid", out_valid, 1'b1);
        check("t2_word2_data", out_data, 8'h3C);
        idle(1'b1);
        check("t2_drained", out_valid, 1'b0);

        // Test 3: drain 8'h01 in the same cycle 8'hFF loads.
        send_beats(8'h01, par(8'h01), BEATS, 1'b0);
        send_beats(8'hFF, par(8'hFF), BEATS - 1, 1'b0);
        cycle(1'b0, 1'b1, beat_bit(8'hFF, par(8'hFF), BEATS - 1), 1'b1, rdy);
        check("t3_no_bubble", out_valid, 1'b1);
        check("t3_new_word", out_data, 8'hFF);
        idle(1'b1);

        // Test 4: flush after three beats, with a beat offered in the flush cycle.
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0, rdy);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, rdy);
        send_beats(8'h0F, par(8'h0F), BEATS, 1'b0);
        check("t4_valid", out_valid, 1'b1);
        check("t4_data", out_data, 8'h0F);
        idle(1'b1);

        // Test 5: asynchronous reset mid-word with a word held.
        send_beats(8'h01, par(8'h01), BEATS, 1'b0);
        send_beats(8'h5A, par(8'h5A), 5, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", out_valid, 1'b0);
        check("t5_async_data", out_data, 8'h00);
        check("t5_async_perr", out_perr, 1'b0);
        check("t5_async_ready", in_ready, 1'b1);
        bits.delete();
        exp_q.delete();
        flush = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_beats(8'h96, par(8'h96), BEATS, 1'b1);
        check("t5_fresh_word", out_data, 8'h96);
        idle(1'b1);

`ifdef PARITY_CHECK_EN
        // Test 6: parity beat checking.
        send_beats(8'h07, 1'b1, BEATS, 1'b1);
        check("t6_perr_clear", out_perr, 1'b0);
        send_beats(8'h07, 1'b0, BEATS, 1'b1);
        check("t6_perr_set", out_perr, 1'b1);
        idle(1'b1);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
